// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: multi-cycle load-use stalls, store-data exemption,
// branch flush, memory-busy freeze and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
    parameter int REG_AW    = 5,
    parameter int MEM_LAT   = 2,
    parameter int STORE_FWD = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic              i_id_is_store,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_branch_tkn,
    input  logic              i_mem_busy,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_id_ex_bubble,
    output logic              o_if_id_flush,
    output logic [CNT_W-1:0]  o_stall_cycles
);

    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic          w_h1;
    logic          w_h2;
    logic          w_haz;
    logic          w_rs2_only;
    logic          w_sub;
    logic [CW-1:0] w_need;

    logic w_pc_write;
    logic w_if_id_write;
    logic w_bubble;
    logic w_flush;

    assign w_h1       = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_h2       = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign w_haz      = i_ex_mem_read && (i_ex_rd != '0) && (w_h1 || w_h2);
    assign w_rs2_only = w_h2 && !w_h1 && i_id_is_store;
    // Store data is forwarded at MEM, so a data-only dependency waits one cycle less.
    assign w_sub      = (STORE_FWD != 0) && w_rs2_only;
    assign w_need     = CW'(MEM_LAT) - CW'(w_sub);

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        if (i_mem_busy) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
        end else if (i_ex_branch_tkn) begin
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == S_STALL) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_cnt_nxt     = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
                w_state_nxt = S_IDLE;
            end
        end else if (w_haz && (w_need != '0)) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            if (w_need > CW'(1)) begin
                w_state_nxt = S_STALL;
                w_cnt_nxt   = w_need - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    // Reset overrides the Mealy outputs combinationally so the pipe holds immediately.
    assign o_pc_write     = rst_n && w_pc_write;
    assign o_if_id_write  = rst_n && w_if_id_write;
    assign o_id_ex_bubble = !rst_n || w_bubble;
    assign o_if_id_flush  = rst_n && w_flush;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: three instances (MEM_LAT 1, 2, 3) share the
// same stimulus; control outputs are checked as {pc_write, if_id_write, bubble, flush}.
module tb_hazard_ctrl_mc;

    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0010;
    localparam logic [3:0] C_BUSY  = 4'b0000;
    localparam logic [3:0] C_BR    = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] idRs1, idRs2, exRd;
    logic       useRs1, useRs2, isStore, memRead, brTkn, memBusy;

    logic        pc1, ifid1, bub1, fl1;
    logic        pc2, ifid2, bub2, fl2;
    logic        pc3, ifid3, bub3, fl3;
    logic [15:0] sc1, sc2;
    logic [3:0]  sc3;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(5), .MEM_LAT(1), .STORE_FWD(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .i_id_rs1(idRs1), .i_id_rs2(idRs2),
        .i_id_use_rs1(useRs1), .i_id_use_rs2(useRs2), .i_id_is_store(isStore),
        .i_ex_rd(exRd), .i_ex_mem_read(memRead), .i_ex_branch_tkn(brTkn),
        .i_mem_busy(memBusy), .o_pc_write(pc1), .o_if_id_write(ifid1),
        .o_id_ex_bubble(bub1), .o_if_id_flush(fl1), .o_stall_cycles(sc1));

    hazard_ctrl_mc #(.REG_AW(5), .MEM_LAT(2), .STORE_FWD(1), .CNT_W(16)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .i_id_rs1(idRs1), .i_id_rs2(idRs2),
        .i_id_use_rs1(useRs1), .i_id_use_rs2(useRs2), .i_id_is_store(isStore),
        .i_ex_rd(exRd), .i_ex_mem_read(memRead), .i_ex_branch_tkn(brTkn),
        .i_mem_busy(memBusy), .o_pc_write(pc2), .o_if_id_write(ifid2),
        .o_id_ex_bubble(bub2), .o_if_id_flush(fl2), .o_stall_cycles(sc2));

    hazard_ctrl_mc #(.REG_AW(5), .MEM_LAT(3), .STORE_FWD(1), .CNT_W(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .i_id_rs1(idRs1), .i_id_rs2(idRs2),
        .i_id_use_rs1(useRs1), .i_id_use_rs2(useRs2), .i_id_is_store(isStore),
        .i_ex_rd(exRd), .i_ex_mem_read(memRead), .i_ex_branch_tkn(brTkn),
        .i_mem_busy(memBusy), .o_pc_write(pc3), .o_if_id_write(ifid3),
        .o_id_ex_bubble(bub3), .o_if_id_flush(fl3), .o_stall_cycles(sc3));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic st,
                                 input logic [4:0] rd, input logic mrd,
                                 input logic br, input logic busy);
        idRs1   = rs1;
        idRs2   = rs2;
        useRs1  = u1;
        useRs2  = u2;
        isStore = st;
        exRd    = rd;
        memRead = mrd;
        brTkn   = br;
        memBusy = busy;
    endtask

    // Canned pipeline situations used throughout the sequence.
    task automatic idleIn();          applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0); endtask
    task automatic addAfterLoad();    applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd5, 1, 0, 0); endtask
    task automatic addAfterBubble();  applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 0, 0); endtask
    task automatic busyIn();          applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 0, 1); endtask

    task automatic toNegedge();
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idleIn();
        nextCycle();
        nextCycle();
        checkOutput("reset_l3_ctl", {pc3, ifid3, bub3, fl3}, C_STALL);
        checkOutput("reset_l1_ctl", {pc1, ifid1, bub1, fl1}, C_STALL);
        checkOutput("reset_l3_sc", sc3, 4'd0);
        rst_n = 1'b1;
        toNegedge();
        checkOutput("idle_l3_ctl", {pc3, ifid3, bub3, fl3}, C_RUN);
        nextCycle();

        // ld x5 in EX, add x6,x5,x1 in ID: 1/2/3 stall cycles per latency
        addAfterLoad(); toNegedge();
        checkOutput("s1_l1", {pc1, ifid1, bub1, fl1}, C_STALL);
        checkOutput("s1_l2", {pc2, ifid2, bub2, fl2}, C_STALL);
        checkOutput("s1_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        addAfterBubble(); toNegedge();
        checkOutput("s2_l1", {pc1, ifid1, bub1, fl1}, C_RUN);
        checkOutput("s2_l2", {pc2, ifid2, bub2, fl2}, C_STALL);
        checkOutput("s2_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        toNegedge();
        checkOutput("s3_l2", {pc2, ifid2, bub2, fl2}, C_RUN);
        checkOutput("s3_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        toNegedge();
        checkOutput("s4_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        checkOutput("s4_sc3", sc3, 4'd3);
        checkOutput("s4_sc2", sc2, 16'd2);
        checkOutput("s4_sc1", sc1, 16'd1);
        nextCycle();

        // ld x5; sw x5,0(x2): store-data-only dependency waits one cycle less
        applyStimulus(5'd2, 5'd5, 1, 1, 1, 5'd5, 1, 0, 0); toNegedge();
        checkOutput("swdata_l1", {pc1, ifid1, bub1, fl1}, C_RUN);
        checkOutput("swdata_l2", {pc2, ifid2, bub2, fl2}, C_STALL);
        checkOutput("swdata_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        idleIn(); toNegedge();
        checkOutput("swdata2_l2", {pc2, ifid2, bub2, fl2}, C_RUN);
        checkOutput("swdata2_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        // ld x5; sw x7,0(x5): base address dependency takes the full latency
        applyStimulus(5'd5, 5'd7, 1, 1, 1, 5'd5, 1, 0, 0); toNegedge();
        checkOutput("swbase_l1", {pc1, ifid1, bub1, fl1}, C_STALL);
        checkOutput("swbase_l2", {pc2, ifid2, bub2, fl2}, C_STALL);
        checkOutput("swbase_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        // load into x0 with ID reading x0 never stalls
        applyStimulus(5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 0, 0); toNegedge();
        checkOutput("x0_l1", {pc1, ifid1, bub1, fl1}, C_RUN);
        checkOutput("x0_l2", {pc2, ifid2, bub2, fl2}, C_STALL);
        checkOutput("x0_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        toNegedge();
        checkOutput("x0b_l2", {pc2, ifid2, bub2, fl2}, C_RUN);
        checkOutput("x0b_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        toNegedge();
        checkOutput("x0c_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        checkOutput("x0c_sc3", sc3, 4'd8);
        checkOutput("x0c_sc1", sc1, 16'd2);
        nextCycle();

        // stall in progress frozen by mem_busy for two cycles
        addAfterLoad(); toNegedge();
        checkOutput("busy0_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            busyIn(); toNegedge();
            checkOutput($sformatf("busy%0d_l3", i + 1), {pc3, ifid3, bub3, fl3}, C_BUSY);
            checkOutput($sformatf("busy%0d_l1", i + 1), {pc1, ifid1, bub1, fl1}, C_BUSY);
            nextCycle();
        end
        addAfterBubble(); toNegedge();
        checkOutput("busy3_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        checkOutput("busy3_l1", {pc1, ifid1, bub1, fl1}, C_RUN);
        nextCycle();
        toNegedge();
        checkOutput("busy4_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        toNegedge();
        checkOutput("busy5_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        checkOutput("busy5_sc3", sc3, 4'd13);
        nextCycle();

        // taken branch together with a hazard: flush wins, no stall follows
        applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd5, 1, 1, 0); toNegedge();
        checkOutput("br_l1", {pc1, ifid1, bub1, fl1}, C_BR);
        checkOutput("br_l2", {pc2, ifid2, bub2, fl2}, C_BR);
        checkOutput("br_l3", {pc3, ifid3, bub3, fl3}, C_BR);
        nextCycle();
        idleIn(); toNegedge();
        checkOutput("br_after_l2", {pc2, ifid2, bub2, fl2}, C_RUN);
        checkOutput("br_after_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        nextCycle();
        // taken branch cancels a stall already in progress
        addAfterLoad(); toNegedge();
        checkOutput("brmid0_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        nextCycle();
        applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 1, 0); toNegedge();
        checkOutput("brmid1_l3", {pc3, ifid3, bub3, fl3}, C_BR);
        nextCycle();
        idleIn(); toNegedge();
        checkOutput("brmid2_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        checkOutput("brmid2_sc3", sc3, 4'd14);
        nextCycle();

        // drive the 4-bit counter past all-ones
        for (int i = 0; i < 4; i++) begin
            busyIn();
            nextCycle();
        end
        idleIn(); toNegedge();
        checkOutput("sat_sc3", sc3, 4'd15);
        nextCycle();
        busyIn(); nextCycle();
        idleIn(); toNegedge();
        checkOutput("sat_hold_sc3", sc3, 4'd15);
        checkOutput("sat_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        nextCycle();

        // reset asserted mid-stall, with a branch also present
        addAfterLoad(); nextCycle();
        applyStimulus(5'd5, 5'd1, 1, 1, 0, 5'd0, 0, 1, 0);
        #1;
        checkOutput("rstmid_pre_l3", {pc3, ifid3, bub3, fl3}, C_BR);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_l3", {pc3, ifid3, bub3, fl3}, C_STALL);
        checkOutput("rstmid_l1", {pc1, ifid1, bub1, fl1}, C_STALL);
        checkOutput("rstmid_sc3", sc3, 4'd0);
        idleIn();
        nextCycle();
        rst_n = 1'b1;
        toNegedge();
        checkOutput("rstrel_l3", {pc3, ifid3, bub3, fl3}, C_RUN);
        checkOutput("rstrel_sc3", sc3, 4'd0);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
